// File: rtl/vn_lut_page_loader_pkg.sv
// Shared sizing for the VN LUT write path. The loader and sym_vn_lut both take
// their entry width, address width and page length from here.
package vn_lut_page_loader_pkg;

  localparam int VN_QUANT_BITS = 3;
  localparam int VN_ADDR_WIDTH = 5;
  localparam int VN_LOAD_CYCLE = 32;

endpackage

// File: rtl/vn_lut_page_loader.sv
// Write-side sequencer for the replicated VN LUT: turns a valid/ready stream of
// one page of entries into in-order writes on both replica ports.
module vn_lut_page_loader
  import vn_lut_page_loader_pkg::*;
#(
  parameter int QUANT_BITS = VN_QUANT_BITS,
  parameter int ADDR_WIDTH = VN_ADDR_WIDTH,
  parameter int LOAD_CYCLE = VN_LOAD_CYCLE
) (
  input  logic                  write_clk,
  input  logic                  rstn,
  input  logic                  load_start,
  input  logic                  load_abort,
  input  logic                  in_valid,
  input  logic [QUANT_BITS-1:0] in_data,
  output logic                  in_ready,
  output logic [QUANT_BITS-1:0] lut_in_replicate_0,
  output logic [ADDR_WIDTH-1:0] write_addr_replicate_0,
  output logic [QUANT_BITS-1:0] lut_in_replicate_1,
  output logic [ADDR_WIDTH-1:0] write_addr_replicate_1,
  output logic                  we,
  output logic                  busy,
  output logic                  load_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_CYCLE - 1);

  state_e                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next;
  logic                  transfer;
  logic                  commit;

  assign in_ready = (state == ST_LOAD);
  assign transfer = in_valid & in_ready;
  // An entry handed over in the abort cycle is dropped so nothing is written after an abort.
  assign commit   = transfer & ~load_abort;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (load_start && !load_abort) begin
          state_next = ST_LOAD;
          cnt_next   = '0;
        end
      end
      ST_LOAD: begin
        if (load_abort) begin
          state_next = ST_IDLE;
        end else if (transfer) begin
          if (cnt == LAST_ADDR) state_next = ST_FLUSH;
          else                  cnt_next   = cnt + 1'b1;
        end
      end
      ST_FLUSH: state_next = load_abort ? ST_IDLE : ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      we                     <= 1'b0;
      busy                   <= 1'b0;
      load_done              <= 1'b0;
      lut_in_replicate_0     <= '0;
      write_addr_replicate_0 <= '0;
      lut_in_replicate_1     <= '0;
      write_addr_replicate_1 <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      we        <= commit;
      busy      <= (state_next != ST_IDLE);
      load_done <= (state == ST_FLUSH) && !load_abort;
      // Separate register per replica keeps each LUT port on its own driver.
      if (commit) begin
        lut_in_replicate_0     <= in_data;
        write_addr_replicate_0 <= cnt;
        lut_in_replicate_1     <= in_data;
        write_addr_replicate_1 <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_vn_lut_page_loader.sv
// Directed bench for vn_lut_page_loader: full pages, bubbles, abort, ignored
// starts, mid-page reset, and a 24-entry page instance.
module tb_vn_lut_page_loader;

  logic       write_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load_start = 1'b0;
  logic       load_abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = 3'd0;

  logic       in_ready, we, busy, load_done;
  logic [2:0] lut_in_replicate_0, lut_in_replicate_1;
  logic [4:0] write_addr_replicate_0, write_addr_replicate_1;

  logic       s_in_ready, s_we, s_busy, s_load_done;
  logic [2:0] s_lut_0, s_lut_1;
  logic [4:0] s_addr_0, s_addr_1;

  int n_checks = 0;
  int n_fail   = 0;

  vn_lut_page_loader #(.QUANT_BITS(3), .ADDR_WIDTH(5), .LOAD_CYCLE(32)) dut (
    .write_clk(write_clk), .rstn(rstn), .load_start(load_start), .load_abort(load_abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .lut_in_replicate_0(lut_in_replicate_0), .write_addr_replicate_0(write_addr_replicate_0),
    .lut_in_replicate_1(lut_in_replicate_1), .write_addr_replicate_1(write_addr_replicate_1),
    .we(we), .busy(busy), .load_done(load_done)
  );

  vn_lut_page_loader #(.QUANT_BITS(3), .ADDR_WIDTH(5), .LOAD_CYCLE(24)) dut_short (
    .write_clk(write_clk), .rstn(rstn), .load_start(load_start), .load_abort(load_abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .lut_in_replicate_0(s_lut_0), .write_addr_replicate_0(s_addr_0),
    .lut_in_replicate_1(s_lut_1), .write_addr_replicate_1(s_addr_1),
    .we(s_we), .busy(s_busy), .load_done(s_load_done)
  );

  always #5 write_clk = ~write_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge write_clk);
    @(negedge write_clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; load_start = 1'b1; in_valid = 1'b1; in_data = 3'd5;
    tick(); tick();
    n_checks++;
    if ({in_ready, we, busy, load_done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, we, busy, load_done});
    end
    n_checks++;
    if ({lut_in_replicate_0, write_addr_replicate_0, lut_in_replicate_1, write_addr_replicate_1} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000",
        {lut_in_replicate_0, write_addr_replicate_0, lut_in_replicate_1, write_addr_replicate_1});
    end
    load_start = 1'b0; in_valid = 1'b0;
    rstn = 1'b1;
    tick(); tick();
    n_checks++;
    if ({in_ready, busy, we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 000", {in_ready, busy, we});
    end
  endtask

  task automatic test_full_page();
    start_load();
    n_checks++;
    if ({in_ready, busy} !== 2'b11) begin
      n_fail++; $display("FAIL full_enter_load: got %b expected 11", {in_ready, busy});
    end
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 3'(i % 8);
      tick();
      n_checks++;
      if ({we, write_addr_replicate_0, lut_in_replicate_0} !== {1'b1, 5'(i), 3'(i % 8)}) begin
        n_fail++; $display("FAIL full_write[%0d]: got we=%b addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
          i, we, write_addr_replicate_0, lut_in_replicate_0, i, i % 8);
      end
      n_checks++;
      if ({write_addr_replicate_1, lut_in_replicate_1} !== {5'(i), 3'(i % 8)}) begin
        n_fail++; $display("FAIL full_replica[%0d]: got addr=%0d data=%0d expected addr=%0d data=%0d",
          i, write_addr_replicate_1, lut_in_replicate_1, i, i % 8);
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, load_done} !== 2'b00) begin
      n_fail++; $display("FAIL full_flush: got in_ready,load_done=%b expected 00", {in_ready, load_done});
    end
    tick();
    n_checks++;
    if ({load_done, we, busy} !== 3'b101) begin
      n_fail++; $display("FAIL full_done: got load_done,we,busy=%b expected 101", {load_done, we, busy});
    end
    tick();
    n_checks++;
    if ({load_done, busy, in_ready} !== 3'b000) begin
      n_fail++; $display("FAIL full_idle: got load_done,busy,in_ready=%b expected 000", {load_done, busy, in_ready});
    end
  endtask

  task automatic test_bubbles();
    int sent = 0;
    int dut_writes = 0;
    int cyc = 0;
    logic v;
    start_load();
    while (sent < 32 && cyc < 200) begin
      v = (cyc % 3 == 0);
      in_valid = v; in_data = 3'(sent % 8);
      tick();
      if (we === 1'b1) dut_writes++;
      n_checks++;
      if (v) begin
        if ({we, write_addr_replicate_0, lut_in_replicate_0, write_addr_replicate_1} !== {1'b1, 5'(sent), 3'(sent % 8), 5'(sent)}) begin
          n_fail++; $display("FAIL bubble_write[%0d]: got we=%b addr=%0d data=%0d addr1=%0d expected addr=%0d data=%0d",
            sent, we, write_addr_replicate_0, lut_in_replicate_0, write_addr_replicate_1, sent, sent % 8);
        end
        sent++;
      end else begin
        if ({we, write_addr_replicate_0} !== {1'b0, 5'(sent - 1)}) begin
          n_fail++; $display("FAIL bubble_gap[%0d]: got we=%b addr=%0d expected we=0 addr=%0d",
            cyc, we, write_addr_replicate_0, sent - 1);
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    tick();
    if (we === 1'b1) dut_writes++;
    n_checks++;
    if (load_done !== 1'b1) begin
      n_fail++; $display("FAIL bubble_done: got load_done=%b expected 1", load_done);
    end
    n_checks++;
    if (dut_writes != 32) begin
      n_fail++; $display("FAIL bubble_count: got %0d writes expected 32", dut_writes);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen = 0;
    start_load();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 3'(i % 8);
      tick();
      n_checks++;
      if ({we, write_addr_replicate_0} !== {1'b1, 5'(i)}) begin
        n_fail++; $display("FAIL abort_pre[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, we, write_addr_replicate_0, i);
      end
    end
    load_abort = 1'b1; in_valid = 1'b1; in_data = 3'd7;
    tick();
    load_abort = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({we, in_ready, busy, write_addr_replicate_0} !== {3'b000, 5'd9}) begin
      n_fail++; $display("FAIL abort_stop: got we=%b in_ready=%b busy=%b addr=%0d expected 0 0 0 9",
        we, in_ready, busy, write_addr_replicate_0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load_done === 1'b1 || we === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d cycles with load_done/we expected 0", done_seen);
    end
    load_start = 1'b1; load_abort = 1'b1;
    tick();
    load_start = 1'b0; load_abort = 1'b0;
    n_checks++;
    if ({in_ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL abort_beats_start: got in_ready,busy=%b expected 00", {in_ready, busy});
    end
    start_load();
    in_valid = 1'b1; in_data = 3'd2;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({we, write_addr_replicate_0, lut_in_replicate_0} !== {1'b1, 5'd0, 3'd2}) begin
      n_fail++; $display("FAIL abort_restart: got we=%b addr=%0d data=%0d expected we=1 addr=0 data=2",
        we, write_addr_replicate_0, lut_in_replicate_0);
    end
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    int done_cnt = 0;
    start_load();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1; in_data = 3'(i % 8);
      load_start = (i % 5 == 2);
      tick();
      if (load_done === 1'b1) done_cnt++;
      n_checks++;
      if ({we, write_addr_replicate_0} !== {1'b1, 5'(i)}) begin
        n_fail++; $display("FAIL ignore_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, we, write_addr_replicate_0, i);
      end
    end
    load_start = 1'b0; in_valid = 1'b0;
    tick();
    if (load_done === 1'b1) done_cnt++;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    if (load_done === 1'b1) done_cnt++;
    n_checks++;
    if ({in_ready, busy} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_done_start: got in_ready,busy=%b expected 00", {in_ready, busy});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_page();
    start_load();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 3'(i % 8);
      tick();
    end
    n_checks++;
    if ({we, write_addr_replicate_0} !== {1'b1, 5'd15}) begin
      n_fail++; $display("FAIL midrst_pre: got we=%b addr=%0d expected we=1 addr=15", we, write_addr_replicate_0);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({we, busy, in_ready, load_done} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_async: got we,busy,in_ready,load_done=%b expected 0000", {we, busy, in_ready, load_done});
    end
    in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    test_full_page();
  endtask

  task automatic test_short_page();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start_load();
    for (int i = 0; i < 24; i++) begin
      in_valid = 1'b1; in_data = 3'(i % 8);
      tick();
      n_checks++;
      if ({s_we, s_addr_0, s_lut_0, s_addr_1, s_lut_1} !== {1'b1, 5'(i), 3'(i % 8), 5'(i), 3'(i % 8)}) begin
        n_fail++; $display("FAIL short_write[%0d]: got we=%b addr=%0d data=%0d addr1=%0d data1=%0d expected addr=%0d data=%0d",
          i, s_we, s_addr_0, s_lut_0, s_addr_1, s_lut_1, i, i % 8);
      end
    end
    n_checks++;
    if ({s_in_ready, s_load_done} !== 2'b00) begin
      n_fail++; $display("FAIL short_flush: got in_ready,load_done=%b expected 00", {s_in_ready, s_load_done});
    end
    in_data = 3'd0;
    tick();
    n_checks++;
    if ({s_load_done, s_we, s_addr_0} !== {2'b10, 5'd23}) begin
      n_fail++; $display("FAIL short_done: got load_done=%b we=%b addr=%0d expected 1 0 23", s_load_done, s_we, s_addr_0);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if ({s_busy, s_we, s_load_done} !== 3'b000) begin
      n_fail++; $display("FAIL short_idle: got busy,we,load_done=%b expected 000", {s_busy, s_we, s_load_done});
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_page();
    test_bubbles();
    test_abort();
    test_start_ignored();
    test_reset_mid_page();
    test_short_page();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
